exec_stage_mc: RTL and testbench
================================

EXEC_STAGE_MC -- requirements
Module: exec_stage_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width (>=8).
REQ-002 SHALL have parameter PC_W, default 64, PC/target width (>=DATA_W).
REQ-003 SHALL have parameter MUL_LAT, default 3, multiply latency in cycles (1..15).
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  in  1  upstream has an instruction.
REQ-007 SHALL have port in_ready  out  1  stage accepts this cycle; transfer = in_valid & in_ready.
REQ-008 SHALL have port in_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 BRANCH, 111 NOP.
REQ-009 SHALL have ports in_a, in_b  in  DATA_W  operands; for BRANCH in_b is the signed byte displacement.
REQ-010 SHALL have port in_pc  in  PC_W  instruction PC.
REQ-011 SHALL have port in_rd  in  5  destination register.
REQ-012 SHALL have ports in_reg_write, in_icc_write, in_annul  in  1 each  writeback enable, icc update enable, branch annul bit.
REQ-013 SHALL have port in_cond  in  4  branch condition.
REQ-014 SHALL have port in_flush  in  1  synchronous pipeline flush.
REQ-015 SHALL have port out_valid  out  1  result register holds a result.
REQ-016 SHALL have port out_ready  in  1  downstream (memory) accepts; transfer = out_valid & out_ready.
REQ-017 SHALL have ports out_res  out  DATA_W, out_rd  out  5, out_reg_write  out  1  registered result fields.
REQ-018 SHALL have port out_icc  out  4  current {N,Z,V,C}.
REQ-019 SHALL have ports out_redirect  out  1, out_target  out  PC_W  taken-branch redirect, valid with out_valid.

Function
REQ-020 SHALL implement FSM IDLE, MUL_BUSY; output register full/empty tracked separately.
REQ-021 in_ready SHALL be 1 iff state IDLE and (output register empty or out_ready=1) and in_flush=0.
REQ-022 Single-cycle ops (ADD..XOR, BRANCH, NOP) SHALL load the output register on the accept edge; out_valid high next cycle; throughput 1/cycle.
REQ-023 Accepted MUL SHALL enter MUL_BUSY with counter=MUL_LAT-1; output register loads MUL_LAT cycles after accept; FSM then returns to IDLE.
REQ-024 If the output register is still full when the MUL counter reaches 0, the FSM SHALL hold in MUL_BUSY with the product until the register frees.
REQ-025 Arithmetic SHALL be modulo 2^DATA_W; MUL result = low DATA_W bits of unsigned product.
REQ-026 icc SHALL be N=res msb, Z=(res==0); ADD: C=carry-out, V=signed overflow; SUB a-b: C=borrow, V=signed overflow; logic/MUL: V=C=0.
REQ-027 icc register SHALL update on the edge the instruction's result loads the output register, only if in_icc_write=1 and not annulled.
REQ-028 BRANCH taken conditions: 1000 always, 0000 never, 0001 Z, 1001 !Z, 0011 N^V, 1011 !(N^V); other codes never taken; evaluated on icc including any update from the instruction loading the same edge's predecessor.
REQ-029 Taken branch SHALL set out_redirect=1, out_target=in_pc+sign_extend(in_b) modulo 2^PC_W; branch out_reg_write=0.
REQ-030 Annul-pending SHALL set when a BRANCH with in_annul=1 is either not taken or has cond 1000.
REQ-031 Next accepted instruction while annul-pending SHALL be consumed with no output, no icc update, no MUL start; annul-pending then clears.
REQ-032 in_flush=1 SHALL, on that edge, clear out_valid, annul-pending and abort MUL_BUSY to IDLE; icc retained; flush overrides acceptance.
REQ-033 Output register SHALL hold all out_* fields stable while out_valid=1 and out_ready=0.

Reset
REQ-034 reset=0 SHALL asynchronously force IDLE, counter=0, annul-pending=0, icc=0, out_valid=0, out_res=0, out_rd=0, out_reg_write=0, out_redirect=0, out_target=0.
REQ-035 in_ready SHALL be 1 combinationally after reset release with in_flush=0; reset mid-MUL discards the product.

Verification
REQ-036 ADD a=0x7FFFFFFF b=1 icc_write=1, out_ready=1 -> next cycle out_res=0x80000000, out_icc=1010.
REQ-037 MUL a=6 b=7 MUL_LAT=3 -> in_ready=0 for 3 cycles, out_valid on 3rd edge after accept, out_res=42.
REQ-038 SUB 5-5 icc_write=1 then BRANCH cond 0001 pc=0x100 b=-8 -> out_redirect=1, out_target=0xF8.
REQ-039 BRANCH cond 0001 annul=1 with Z=0, then ADD rd=3 -> ADD consumed, no out_valid, icc unchanged.
REQ-040 out_ready=0 holding ADD result, MUL accepted with MUL_LAT=1 -> MUL_BUSY held; product appears cycle after out_ready=1.
REQ-041 in_flush during MUL_BUSY, then reset=0 mid-stream -> out_valid=0, in_ready=1, all outputs 0.

Source files
------------

// File: rtl/exec_stage_mc.sv
// Execute stage: single-cycle ALU and branch resolution, plus a multi-cycle multiplier.
// It has one output register, an icc flag register and branch-annul tracking.
module exec_stage_mc #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 64,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  input  logic              in_icc_write,
  input  logic              in_annul,
  input  logic [3:0]        in_cond,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [4:0]        out_rd,
  output logic              out_reg_write,
  output logic [3:0]        out_icc,
  output logic              out_redirect,
  output logic [PC_W-1:0]   out_target
);

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
                         OP_XOR = 3'b100, OP_MUL = 3'b101, OP_BR  = 3'b110;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              annul_q;
  logic [3:0]        icc_q;
  logic              out_valid_q, out_reg_write_q, out_redirect_q;
  logic [DATA_W-1:0] out_res_q, mul_res_q;
  logic [4:0]        out_rd_q, mul_rd_q;
  logic [PC_W-1:0]   out_target_q;
  logic              mul_rw_q, mul_iw_q;

  logic [DATA_W:0]   sum_d;
  logic [DATA_W-1:0] diff_d, res_d, prod_d;
  logic              v_d, c_d, alu_op_d, taken_d, accept_d, out_free_d;
  logic [3:0]        icc_d;
  logic [PC_W-1:0]   disp_d, target_d;

  function automatic logic cond_true(input logic [3:0] c, input logic [2:0] nzv);
    case (c)
      4'b1000: cond_true = 1'b1;
      4'b0001: cond_true = nzv[1];
      4'b1001: cond_true = !nzv[1];
      4'b0011: cond_true = nzv[2] ^ nzv[0];
      4'b1011: cond_true = !(nzv[2] ^ nzv[0]);
      default: cond_true = 1'b0;
    endcase
  endfunction

  assign out_free_d = !out_valid_q || out_ready;
  assign in_ready   = (state_q == IDLE) && out_free_d && !in_flush;
  assign accept_d   = in_valid && in_ready;

  assign sum_d    = {1'b0, in_a} + {1'b0, in_b};
  assign diff_d   = in_a - in_b;
  assign prod_d   = in_a * in_b;
  assign disp_d   = PC_W'($signed(in_b));
  assign target_d = in_pc + disp_d;
  assign taken_d  = (in_op == OP_BR) && cond_true(in_cond, icc_q[3:1]);
  assign alu_op_d = (in_op <= OP_XOR);

  always_comb begin
    res_d = '0;
    v_d   = 1'b0;
    c_d   = 1'b0;
    case (in_op)
      OP_ADD: begin
        res_d = sum_d[DATA_W-1:0];
        c_d   = sum_d[DATA_W];
        v_d   = (in_a[DATA_W-1] == in_b[DATA_W-1]) && (res_d[DATA_W-1] != in_a[DATA_W-1]);
      end
      OP_SUB: begin
        res_d = diff_d;
        c_d   = in_a < in_b;
        v_d   = (in_a[DATA_W-1] != in_b[DATA_W-1]) && (res_d[DATA_W-1] != in_a[DATA_W-1]);
      end
      OP_AND:  res_d = in_a & in_b;
      OP_OR:   res_d = in_a | in_b;
      OP_XOR:  res_d = in_a ^ in_b;
      default: res_d = '0;
    endcase
    icc_d = {res_d[DATA_W-1], res_d == '0, v_d, c_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      annul_q         <= 1'b0;
      icc_q           <= '0;
      out_valid_q     <= 1'b0;
      out_res_q       <= '0;
      out_rd_q        <= '0;
      out_reg_write_q <= 1'b0;
      out_redirect_q  <= 1'b0;
      out_target_q    <= '0;
      mul_res_q       <= '0;
      mul_rd_q        <= '0;
      mul_rw_q        <= 1'b0;
      mul_iw_q        <= 1'b0;
    end else if (in_flush) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      annul_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            if (annul_q) begin
              annul_q <= 1'b0;
            end else if (in_op == OP_MUL) begin
              state_q   <= MUL_BUSY;
              cnt_q     <= 4'(MUL_LAT - 1);
              mul_res_q <= prod_d;
              mul_rd_q  <= in_rd;
              mul_rw_q  <= in_reg_write;
              mul_iw_q  <= in_icc_write;
            end else begin
              out_valid_q     <= 1'b1;
              out_res_q       <= res_d;
              out_rd_q        <= in_rd;
              out_reg_write_q <= alu_op_d && in_reg_write;
              out_redirect_q  <= taken_d;
              out_target_q    <= taken_d ? target_d : '0;
              if (alu_op_d && in_icc_write) icc_q <= icc_d;
              if (in_op == OP_BR && in_annul && (!taken_d || in_cond == 4'b1000)) annul_q <= 1'b1;
            end
          end
        end
        MUL_BUSY: begin
          // A finished product waits here until the output register can take it.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (out_free_d) begin
            state_q         <= IDLE;
            out_valid_q     <= 1'b1;
            out_res_q       <= mul_res_q;
            out_rd_q        <= mul_rd_q;
            out_reg_write_q <= mul_rw_q;
            out_redirect_q  <= 1'b0;
            out_target_q    <= '0;
            if (mul_iw_q) icc_q <= {mul_res_q[DATA_W-1], mul_res_q == '0, 2'b00};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign out_res       = out_res_q;
  assign out_rd        = out_rd_q;
  assign out_reg_write = out_reg_write_q;
  assign out_icc       = icc_q;
  assign out_redirect  = out_redirect_q;
  assign out_target    = out_target_q;

endmodule

// File: tb/tb_exec_stage_mc.sv
// Directed bench for exec_stage_mc: one instance with MUL_LAT=3 and one with MUL_LAT=1,
// both driven by the same stimulus.
module tb_exec_stage_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_reg_write, in_icc_write, in_annul, in_flush, out_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [63:0] in_pc;
  logic [4:0]  in_rd;
  logic [3:0]  in_cond;

  logic        rdy3, ov3, rw3, redir3, rdy1, ov1, rw1, redir1;
  logic [31:0] res3, res1;
  logic [4:0]  rd3, rd1;
  logic [3:0]  icc3, icc1;
  logic [63:0] tgt3, tgt1;

  int tests = 0;
  int fails = 0;

  exec_stage_mc #(.DATA_W(32), .PC_W(64), .MUL_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy3), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_icc_write(in_icc_write), .in_annul(in_annul), .in_cond(in_cond), .in_flush(in_flush),
    .out_valid(ov3), .out_ready(out_ready), .out_res(res3), .out_rd(rd3),
    .out_reg_write(rw3), .out_icc(icc3), .out_redirect(redir3), .out_target(tgt3)
  );

  exec_stage_mc #(.DATA_W(32), .PC_W(64), .MUL_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_icc_write(in_icc_write), .in_annul(in_annul), .in_cond(in_cond), .in_flush(in_flush),
    .out_valid(ov1), .out_ready(out_ready), .out_res(res1), .out_rd(rd1),
    .out_reg_write(rw1), .out_icc(icc1), .out_redirect(redir1), .out_target(tgt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rw, input logic iw,
                       input logic [3:0] cond, input logic ann, input logic [63:0] pc);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
    in_reg_write = rw; in_icc_write = iw; in_cond = cond; in_annul = ann; in_pc = pc;
    $display("[TB] t=%0t drive op=%b a=%h b=%h rd=%0d cond=%b annul=%b", $time, op, a, b, rd, cond, ann);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_op = 3'b111; in_a = '0; in_b = '0; in_pc = '0;
    in_rd = '0; in_reg_write = 1'b0; in_icc_write = 1'b0; in_annul = 1'b0; in_cond = '0;
    in_flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", ov3, 0);
    chk("rst_out_res", res3, 0);
    chk("rst_out_icc", icc3, 0);
    chk("rst_out_target", tgt3, 0);
    chk("rst_out_redirect", redir3, 0);
    reset = 1'b1; #1;
    chk("release_in_ready", rdy3, 1);

    // ADD overflow into sign bit
    drive(3'b000, 32'h7FFF_FFFF, 32'h1, 5'd5, 1'b1, 1'b1, 4'b0000, 1'b0, 64'h0); #1;
    chk("add_in_ready", rdy3, 1);
    tick();
    chk("add_valid", ov3, 1);
    chk("add_res", res3, 32'h8000_0000);
    chk("add_icc", icc3, 4'b1010);
    chk("add_rd", rd3, 5);
    chk("add_rw", rw3, 1);

    drive(3'b001, 32'd3, 32'd5, 5'd6, 1'b1, 1'b1, 4'b0000, 1'b0, 64'h0); tick();
    chk("sub_borrow_res", res3, 32'hFFFF_FFFE);
    chk("sub_borrow_icc", icc3, 4'b1001);
    drive(3'b000, 32'hFFFF_FFFF, 32'h1, 5'd6, 1'b1, 1'b1, 4'b0000, 1'b0, 64'h0); tick();
    chk("add_carry_res", res3, 0);
    chk("add_carry_icc", icc3, 4'b0101);
    drive(3'b010, 32'h0000_F0F0, 32'h0000_FF00, 5'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 64'h0); tick();
    chk("and_res", res3, 32'h0000_F000);
    chk("and_icc_kept", icc3, 4'b0101);

    // SUB sets Z, then a taken BRANCH on Z with negative displacement
    drive(3'b001, 32'd5, 32'd5, 5'd1, 1'b1, 1'b1, 4'b0000, 1'b0, 64'h0); tick();
    chk("sub_zero_icc", icc3, 4'b0100);
    drive(3'b110, 32'h0, 32'hFFFF_FFF8, 5'd0, 1'b1, 1'b0, 4'b0001, 1'b0, 64'h100); tick();
    chk("br_valid", ov3, 1);
    chk("br_redirect", redir3, 1);
    chk("br_target", tgt3, 64'hF8);
    chk("br_reg_write", rw3, 0);

    // Untaken annulling branch consumes the following ADD
    drive(3'b000, 32'd1, 32'd1, 5'd1, 1'b1, 1'b1, 4'b0000, 1'b0, 64'h0); tick();
    chk("add_clear_icc", icc3, 4'b0000);
    drive(3'b110, 32'h0, 32'h4, 5'd0, 1'b0, 1'b0, 4'b0001, 1'b1, 64'h200); tick();
    chk("br_annul_valid", ov3, 1);
    chk("br_annul_redirect", redir3, 0);
    drive(3'b000, 32'd0, 32'd0, 5'd3, 1'b1, 1'b1, 4'b0000, 1'b0, 64'h0); tick();
    chk("annulled_no_valid", ov3, 0);
    chk("annulled_icc_kept", icc3, 4'b0000);
    drive(3'b000, 32'd2, 32'd3, 5'd4, 1'b1, 1'b0, 4'b0000, 1'b0, 64'h0); tick();
    chk("post_annul_valid", ov3, 1);
    chk("post_annul_res", res3, 5);
    chk("post_annul_rd", rd3, 4);

    // MUL latency 3 (and 1 on the second instance)
    drive(3'b101, 32'd6, 32'd7, 5'd7, 1'b1, 1'b0, 4'b0000, 1'b0, 64'h0); tick();
    idle_in();
    chk("mul_busy1_ready", rdy3, 0);
    chk("mul_busy1_valid", ov3, 0);
    tick();
    chk("mul_busy2_ready", rdy3, 0);
    chk("mul1_valid", ov1, 1);
    chk("mul1_res", res1, 42);
    tick();
    chk("mul_busy3_ready", rdy3, 0);
    chk("mul_busy3_valid", ov3, 0);
    tick();
    chk("mul_done_valid", ov3, 1);
    chk("mul_done_res", res3, 42);
    chk("mul_done_ready", rdy3, 1);
    tick();
    chk("mul_drained", ov3, 0);

    // Backpressure: held ADD, then MUL behind it on the latency-1 instance
    out_ready = 1'b0;
    drive(3'b000, 32'd1, 32'd2, 5'd1, 1'b1, 1'b0, 4'b0000, 1'b0, 64'h0); tick();
    idle_in();
    chk("hold_valid", ov1, 1);
    chk("hold_ready", rdy1, 0);
    tick();
    chk("hold_res_stable", res1, 3);
    chk("hold_rd_stable", rd1, 1);
    drive(3'b101, 32'h0001_0000, 32'h0001_0000, 5'd9, 1'b1, 1'b1, 4'b0000, 1'b0, 64'h0); #1;
    chk("mul_blocked_ready", rdy1, 0);
    out_ready = 1'b1; #1;
    chk("mul_unblocked_ready", rdy1, 1);
    tick();
    idle_in(); out_ready = 1'b0;
    chk("mul_wait_valid", ov1, 0);
    tick();
    chk("mul_wrap_valid", ov1, 1);
    chk("mul_wrap_res", res1, 0);
    chk("mul_wrap_rd", rd1, 9);
    chk("mul_wrap_icc", icc1, 4'b0100);
    tick();
    chk("mul_wrap_hold", ov1, 1);

    // Reset, then flush behaviour
    reset = 1'b0; #1;
    chk("rst2_valid", ov3, 0);
    chk("rst2_ready", rdy3, 1);
    tick(); reset = 1'b1; out_ready = 1'b1;
    drive(3'b000, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b1, 1'b1, 4'b0000, 1'b0, 64'h0); tick();
    chk("add_v_c_icc", icc3, 4'b0111);
    drive(3'b101, 32'd2, 32'd3, 5'd2, 1'b1, 1'b1, 4'b0000, 1'b0, 64'h0); tick();
    idle_in(); in_flush = 1'b1; #1;
    chk("flush_ready", rdy3, 0);
    tick(); in_flush = 1'b0; #1;
    chk("flush_idle_ready", rdy3, 1);
    chk("flush_valid", ov3, 0);
    tick(); tick(); tick();
    chk("flush_mul_discarded", ov3, 0);
    chk("flush_icc_kept", icc3, 4'b0111);

    out_ready = 1'b0;
    drive(3'b000, 32'd4, 32'd4, 5'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 64'h0); tick();
    idle_in(); in_flush = 1'b1;
    chk("pre_flush_valid", ov3, 1);
    tick(); in_flush = 1'b0;
    chk("flush_clears_valid", ov3, 0);

    // Taken always-branch held, then asynchronous reset mid-cycle
    drive(3'b110, 32'h0, 32'h10, 5'd0, 1'b0, 1'b0, 4'b1000, 1'b0, 64'h40); tick();
    idle_in();
    chk("br_always_redirect", redir3, 1);
    chk("br_always_target", tgt3, 64'h50);
    #2 reset = 1'b0; #1;
    chk("async_rst_valid", ov3, 0);
    chk("async_rst_res", res3, 0);
    chk("async_rst_redirect", redir3, 0);
    chk("async_rst_target", tgt3, 0);
    chk("async_rst_icc", icc3, 0);
    chk("async_rst_rd", rd3, 0);
    chk("async_rst_rw", rw3, 0);
    chk("async_rst_ready", rdy3, 1);
    tick(); reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
